// File: rtl/intf_gen_fifo_bank_if.sv
// ----------------------------------------------------------------------------
// intf_gen_fifo_bank interfaces
//
// intf_gen_fifo_bank_if
//   Bundles the bank's bus. Parameters: NCHAN, WIDTH.
//   in_valid  [NCHAN]        per-channel write request   (master -> slave)
//   in_ready  [NCHAN]        per-channel space available (slave -> master)
//   in_data   [NCHAN*WIDTH]  channel c at [c*WIDTH +: WIDTH]
//   out_valid                output stage holds a word   (slave -> master)
//   out_ready                consumer accepts the word   (master -> slave)
//   out_data  [WIDTH]        output word
//   out_chan  [CW]           source channel of out_data
//   checksum  [WIDTH]        only with INTF_GEN_FIFO_BANK_CHECKSUM_EN defined
//
// intf_gen_fifo_bank_chan_if
//   One channel FIFO (storage, pointers, count) living inside its own
//   interface instance. Parameters: WIDTH, DEPTH (>=2, any value).
//   Ports: clk, reset (synchronous, active-high).
//   Controls: push, pop, wr_data. Status: ready, nonempty, rd_data (head).
//   The owner guarantees push only when ready and pop only when nonempty.
// ----------------------------------------------------------------------------

interface intf_gen_fifo_bank_if #(
  parameter int NCHAN = 2,
  parameter int WIDTH = 8
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [NCHAN-1:0]       in_valid;
  logic [NCHAN-1:0]       in_ready;
  logic [NCHAN*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [CW-1:0]          out_chan;

`ifdef INTF_GEN_FIFO_BANK_CHECKSUM_EN
  logic [WIDTH-1:0]       checksum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, checksum
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, checksum
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
`endif
endinterface

interface intf_gen_fifo_bank_chan_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             ready;
  logic             nonempty;

  logic [CNTW-1:0]  count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Status comes from the registered count only, so a pop in the same cycle
  // never opens a slot for a push into a full channel.
  assign ready    = (count != FULL);
  assign nonempty = (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH need not be a power of two, so wrap explicitly.
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count decide what
  // is valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endinterface

// File: rtl/intf_gen_fifo_bank.sv
// ----------------------------------------------------------------------------
// intf_gen_fifo_bank
//
// Multi-channel buffer: one FIFO per input channel, each FIFO held in its own
// generate-instantiated intf_gen_fifo_bank_chan_if. A round-robin arbiter
// drains the channels into a single registered output stage.
//
// Parameters: NCHAN (>=1), WIDTH (>=1), DEPTH (>=2, any value).
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous, active-high; discards all buffered and output words
//   bus    intf_gen_fifo_bank_if.slave: in_valid/in_ready/in_data per channel,
//          out_valid/out_ready/out_data/out_chan, optional checksum
//
// Optional feature macro: INTF_GEN_FIFO_BANK_CHECKSUM_EN
//   When defined, bus.checksum accumulates the XOR of every accepted output
//   word (out_valid && out_ready). When undefined the register is absent.
// ----------------------------------------------------------------------------

module intf_gen_fifo_bank #(
  parameter int NCHAN = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  intf_gen_fifo_bank_if.slave bus
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [NCHAN-1:0] ready_vec;
  logic [NCHAN-1:0] nonempty_vec;
  logic [NCHAN-1:0] pop_vec;
  logic [WIDTH-1:0] head [NCHAN];

  logic [CW-1:0]    rr;
  logic [CW-1:0]    rr_next;
  logic [CW-1:0]    grant;
  logic [CW-1:0]    idx;
  logic             has_word;
  logic             load;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CW-1:0]    out_chan_q;

  // --------------------------------------------------------------------------
  // Per-channel FIFOs
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    intf_gen_fifo_bank_chan_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo (
      .clk   (clk),
      .reset (reset)
    );

    assign fifo.push       = bus.in_valid[c] && fifo.ready;
    assign fifo.pop        = pop_vec[c];
    assign fifo.wr_data    = bus.in_data[c*WIDTH +: WIDTH];
    assign ready_vec[c]    = fifo.ready;
    assign nonempty_vec[c] = fifo.nonempty;
    assign head[c]         = fifo.rd_data;
    assign pop_vec[c]      = load && (grant == CW'(c));
  end

  assign bus.in_ready = ready_vec;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first non-empty channel at or after rr, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before the search loop,
    // so no path leaves it unassigned and no latch is inferred.
    has_word = 1'b0;
    grant    = '0;
    idx      = '0;
    for (int i = 0; i < NCHAN; i++) begin
      idx = CW'((int'(rr) + i) % NCHAN);
      if (!has_word && nonempty_vec[idx]) begin
        has_word = 1'b1;
        grant    = idx;
      end
    end
  end

  assign rr_next = (int'(grant) == NCHAN - 1) ? '0 : grant + CW'(1);

  // A load both fills the output stage and pops the granted channel; while the
  // stage is stalled (valid && !ready) nothing is popped.
  assign load = has_word && (!out_valid_q || bus.out_ready);

  // --------------------------------------------------------------------------
  // Registered output stage and rr pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr          <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= head[grant];
      out_chan_q  <= grant;
      rr          <= rr_next;
    end else if (bus.out_ready) begin
      // Word consumed with nothing to replace it.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

`ifdef INTF_GEN_FIFO_BANK_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      checksum_q <= checksum_q ^ out_data_q;
    end
  end

  assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_intf_gen_fifo_bank.sv
// ----------------------------------------------------------------------------
// tb_intf_gen_fifo_bank
//
// Directed bench for intf_gen_fifo_bank (NCHAN=2, WIDTH=8, DEPTH=4).
// Stimulus pushes the hand-computed expected output words into a scoreboard
// queue; a monitor on the falling edge pops and compares every word the DUT
// hands over (out_valid && out_ready). Direct checks cover reset state,
// in_ready, stall stability, latency and (with the macro) the checksum.
// ----------------------------------------------------------------------------

module tb_intf_gen_fifo_bank;
  localparam int NCHAN = 2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  intf_gen_fifo_bank_if #(.NCHAN(NCHAN), .WIDTH(WIDTH)) bus ();

  intf_gen_fifo_bank #(.NCHAN(NCHAN), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       chan;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: the transfer happens on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data 0x%0h chan %0d, expected no word (t=%0t)",
                 bus.out_data, bus.out_chan, $time);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.data));
        check("out_chan", 32'(bus.out_chan), 32'(e.chan));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic c);
    exp_t e;
    e.data = d;
    e.chan = c;
    sb.push_back(e);
  endtask

  // Present one word on channel c for one cycle; the channel is known to have room.
  task automatic send(input int c, input logic [7:0] d);
    bus.in_valid            = '0;
    bus.in_valid[c]         = 1'b1;
    bus.in_data             = '0;
    bus.in_data[c*8 +: 8]   = d;
    push_exp(d, c[0]);
    tick();
    bus.in_valid = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid !== 1'b0) && n < 100) begin
      tick();
      n++;
    end
    check({name, "_sb_left"}, 32'(sb.size()), 32'd0);
    check({name, "_idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_reset(input int n);
    bus.in_valid = '0;
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // ---- 1: reset with requests asserted ----------------------------------
    reset         = 1'b1;
    bus.in_valid  = 2'b11;
    bus.in_data   = 16'hCDAB;
    bus.out_ready = 1'b0;
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd3);
    tick();
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_chan", 32'(bus.out_chan), 32'd0);
    reset        = 1'b0;
    bus.in_valid = '0;
    tick(2);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd3);

    // ---- 2: fill ch0 with the consumer stalled -----------------------------
    // 0x11 moves into the empty output stage, 0x12..0x15 fill the FIFO.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 2'b01;
      bus.in_data  = {8'h00, 8'(8'h11 + i)};
      check("fill_in_ready", 32'(bus.in_ready[0]), 32'd1);
      push_exp(8'(8'h11 + i), 1'b0);
      tick();
    end
    bus.in_data = {8'h00, 8'h16};
    check("full_in_ready", 32'(bus.in_ready[0]), 32'd0);
    check("full_head", 32'(bus.out_data), 32'h11);
    tick();
    check("full_hold_in_ready", 32'(bus.in_ready[0]), 32'd0);
    check("full_hold_valid", 32'(bus.out_valid), 32'd1);
    // Pop from the full channel while 0x16 is still offered: must not push.
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = '0;
    wait_drain("fill_drain");
    check("fill_end_in_ready", 32'(bus.in_ready), 32'd3);

    // ---- 3/4: round-robin with a 5-cycle stall -----------------------------
    do_reset(1);
    bus.out_ready = 1'b0;
    push_exp(8'hA0, 1'b0);
    push_exp(8'hB0, 1'b1);
    push_exp(8'hA1, 1'b0);
    push_exp(8'hB1, 1'b1);
    bus.in_valid = 2'b11;
    bus.in_data  = {8'hB0, 8'hA0};
    tick();
    bus.in_data  = {8'hB1, 8'hA1};
    tick();
    bus.in_valid = '0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_data", 32'(bus.out_data), 32'hA0);
      check("stall_chan", 32'(bus.out_chan), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    wait_drain("rr_drain");

    // ---- minimum latency: accepted at edge k, valid after edge k+1 --------
    bus.out_ready = 1'b1;
    send(1, 8'h3C);
    check("lat_k_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("lat_k1_valid", 32'(bus.out_valid), 32'd1);
    check("lat_k1_chan", 32'(bus.out_chan), 32'd1);
    wait_drain("lat_drain");

    // ---- 5: reset with three words buffered --------------------------------
    bus.out_ready = 1'b0;
    bus.in_valid  = 2'b11;
    bus.in_data   = {8'h61, 8'h51};
    tick();
    bus.in_valid  = 2'b01;
    bus.in_data   = {8'h00, 8'h52};
    tick();
    bus.in_valid  = '0;
    check("mr_pre_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_valid", 32'(bus.out_valid), 32'd0);
    check("mr_data", 32'(bus.out_data), 32'd0);
    check("mr_in_ready", 32'(bus.in_ready), 32'd3);
    bus.out_ready = 1'b1;
    send(1, 8'h71);
    wait_drain("mr_drain");
    tick(3);
    check("mr_no_stale", 32'(bus.out_valid), 32'd0);

`ifdef INTF_GEN_FIFO_BANK_CHECKSUM_EN
    // ---- 6: checksum -------------------------------------------------------
    do_reset(1);
    check("cks_reset", 32'(bus.checksum), 32'd0);
    bus.out_ready = 1'b1;
    send(0, 8'h0F);
    send(0, 8'hF0);
    wait_drain("cks_drain1");
    check("cks_0f_f0", 32'(bus.checksum), 32'hFF);
    send(0, 8'hFF);
    wait_drain("cks_drain2");
    check("cks_ff", 32'(bus.checksum), 32'h00);
    send(1, 8'h5A);
    wait_drain("cks_drain3");
    check("cks_5a", 32'(bus.checksum), 32'h5A);
`endif

    tick(2);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
